// File: rtl/sr_iter_pkg.sv
// Shared widths, stage count and state encoding for the iterative right shifter.
package sr_iter_pkg;

    localparam int WIDTH     = 32;
    localparam int AMT_W     = 5;
    localparam int SR_STAGES = 5;

    typedef enum logic [1:0] {
        SR_IDLE  = 2'd0,
        SR_SHIFT = 2'd1,
        SR_DONE  = 2'd2
    } sr_state_e;

endpackage

// File: rtl/sr_iter_stage.sv
// One reusable shift stage: conditionally shifts right by 2^stage_i, filling with fill_i.
module sr_stage
    import sr_iter_pkg::*;
(
    input  logic [WIDTH-1:0] data_i,
    input  logic [2:0]       stage_i,
    input  logic             en_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] out_o
);

    logic [WIDTH-1:0] cand [AMT_W];

    // One candidate per shift distance; the stage index picks which one is used.
    for (genvar k = 0; k < AMT_W; k++) begin : g_cand
        localparam int SH = 1 << k;
        assign cand[k] = {{SH{fill_i}}, data_i[WIDTH-1:SH]};
    end

    always_comb begin
        out_o = data_i;
        if (en_i) begin
            case (stage_i)
                3'd0:    out_o = cand[0];
                3'd1:    out_o = cand[1];
                3'd2:    out_o = cand[2];
                3'd3:    out_o = cand[3];
                3'd4:    out_o = cand[4];
                default: out_o = data_i;
            endcase
        end
    end

endmodule

// File: rtl/sr_iter.sv
// Multi-cycle logical/arithmetic right shifter, one amount bit per cycle (16,8,4,2,1).
// state  | meaning
// IDLE   | waiting for ctrl_start
// SHIFT  | applying stage 4-count to acc, busy high
// DONE   | data_resultRDY high for one cycle; a new start is accepted here
module sr_iter
    import sr_iter_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_start,
    input  logic             ctrl_arith,
    input  logic [WIDTH-1:0] data_operand,
    input  logic [AMT_W-1:0] shiftamt,
    output logic [WIDTH-1:0] data_result,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam logic [2:0] LAST_CNT = 3'(SR_STAGES - 1);

    sr_state_e        state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [AMT_W-1:0] amt_q, amt_d;
    logic             arith_q, arith_d;
    logic [2:0]       count_q, count_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [2:0]       stage;
    logic [WIDTH-1:0] stage_out;

    // Largest distance first, so count 0 applies the 16-bit stage.
    assign stage = LAST_CNT - count_q;

    sr_stage u_stage (
        .data_i  (acc_q),
        .stage_i (stage),
        .en_i    (amt_q[stage]),
        .fill_i  (arith_q & acc_q[WIDTH-1]),
        .out_o   (stage_out)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= SR_IDLE;
            acc_q    <= '0;
            amt_q    <= '0;
            arith_q  <= 1'b0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            amt_q    <= amt_d;
            arith_q  <= arith_d;
            count_q  <= count_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        amt_d    = amt_q;
        arith_d  = arith_q;
        count_d  = count_q;
        result_d = result_q;
        case (state_q)
            SR_IDLE, SR_DONE: begin
                if (ctrl_start) begin
                    acc_d   = data_operand;
                    amt_d   = shiftamt;
                    arith_d = ctrl_arith;
                    count_d = '0;
                    state_d = SR_SHIFT;
                end else begin
                    state_d = SR_IDLE;
                end
            end
            SR_SHIFT: begin
                acc_d = stage_out;
                if (count_q == LAST_CNT) begin
                    result_d = stage_out;
                    state_d  = SR_DONE;
                end else begin
                    count_d = count_q + 3'd1;
                end
            end
            default: state_d = SR_IDLE;
        endcase
    end

    assign data_result    = result_q;
    assign data_resultRDY = (state_q == SR_DONE);
    assign busy           = (state_q == SR_SHIFT);

endmodule
